// File: rtl/pq_register_file.sv
// PQ register file: NUM_REGS words, per-entry parallel accelerator writes, full parallel read-out,
// single-word core port and a burst load/unload stream engine.
// Latency: writes visible the cycle after the edge; core read data and unload words are registered (1 cycle).
// Backpressure: the accelerator is never stalled; it blocks core grants and load-stream ready in any cycle
// it writes; unload words are held stable while st_ready_i is low.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   acc_wdata_i / acc_we_i          accelerator per-entry write data / enables
//   rdata_pq_o                      every entry in parallel, straight from the storage flops
//   core_*                          single-word load/store port (req/gnt, rvalid/rdata)
//   ld_start_i / st_start_i         start a burst load / unload of xfer_len_i words from xfer_base_i
//   ld_valid_i / ld_data_i / ld_ready_o   load stream (valid/ready)
//   st_valid_o / st_data_o / st_ready_i   unload stream (valid/ready)
//   busy_o / done_o                 engine active / one-cycle burst completion pulse
module pq_register_file #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    localparam int NUM_REGS  = 2 ** (ADDR_WIDTH - 1),
    localparam int IDX_W     = ADDR_WIDTH - 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] acc_wdata_i,
    input  logic [NUM_REGS-1:0]                 acc_we_i,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rdata_pq_o,
    input  logic                                core_req_i,
    input  logic                                core_we_i,
    input  logic [IDX_W-1:0]                    core_addr_i,
    input  logic [DATA_WIDTH-1:0]               core_wdata_i,
    output logic                                core_gnt_o,
    output logic                                core_rvalid_o,
    output logic [DATA_WIDTH-1:0]               core_rdata_o,
    input  logic                                ld_start_i,
    input  logic                                st_start_i,
    input  logic [IDX_W-1:0]                    xfer_base_i,
    input  logic [ADDR_WIDTH-1:0]               xfer_len_i,
    input  logic                                ld_valid_i,
    input  logic [DATA_WIDTH-1:0]               ld_data_i,
    output logic                                ld_ready_o,
    output logic                                st_valid_o,
    output logic [DATA_WIDTH-1:0]               st_data_o,
    input  logic                                st_ready_i,
    output logic                                busy_o,
    output logic                                done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LEN_ONE = ADDR_WIDTH'(1);

    state_t                               state_q, state_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  mem_q;
    logic [IDX_W-1:0]                     base_q;
    logic [ADDR_WIDTH-1:0]                len_q;
    logic [IDX_W-1:0]                     cnt_q;

    logic                                 acc_any;
    logic                                 start_any;
    logic                                 start_zero;
    logic                                 start_st;
    logic                                 cnt_last;
    logic                                 ld_hs;
    logic                                 st_hs;
    logic [IDX_W-1:0]                     xfer_addr;
    logic [IDX_W-1:0]                     st_fetch_addr;
    logic [DATA_WIDTH-1:0]                st_fetch_data;

    assign rdata_pq_o = mem_q;
    assign acc_any    = |acc_we_i;

    // A start is only taken in IDLE; load wins over a simultaneous unload start.
    assign start_any  = (state_q == IDLE) && (ld_start_i || st_start_i);
    assign start_zero = start_any && (xfer_len_i == '0);
    assign start_st   = (state_q == IDLE) && st_start_i && !ld_start_i && (xfer_len_i != '0);

    // Address arithmetic is IDX_W wide, so base+cnt wraps modulo NUM_REGS for free.
    assign xfer_addr  = base_q + cnt_q;
    assign cnt_last   = ({1'b0, cnt_q} == (len_q - LEN_ONE));
    assign ld_hs      = ld_valid_i && ld_ready_o;
    assign st_hs      = st_valid_o && st_ready_i;

    // Next unload word: the base on a fresh start, otherwise the entry after the one just accepted.
    // An accelerator write landing in the fetch cycle is forwarded so the word is not one cycle stale.
    assign st_fetch_addr = start_st ? xfer_base_i : (xfer_addr + IDX_W'(1));
    assign st_fetch_data = acc_we_i[st_fetch_addr] ? acc_wdata_i[st_fetch_addr] : mem_q[st_fetch_addr];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_any && !start_zero) begin
                    state_d = ld_start_i ? LOAD : STORE;
                end
            end
            LOAD: begin
                if (ld_hs && cnt_last) begin
                    state_d = IDLE;
                end
            end
            STORE: begin
                if (st_hs && cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: combinational outputs ----------------
    always_comb begin
        busy_o     = (state_q != IDLE);
        ld_ready_o = (state_q == LOAD) && !acc_any;
        core_gnt_o = core_req_i && (state_q == IDLE) && !acc_any;
    end

    // ---------------- Storage ----------------
    // Accelerator > load stream > core. The lower two never actually collide with the accelerator
    // because ld_ready_o and core_gnt_o already drop whenever any acc_we_i bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (acc_we_i[k]) begin
                    mem_q[k] <= acc_wdata_i[k];
                end else if (ld_hs && (xfer_addr == IDX_W'(k))) begin
                    mem_q[k] <= ld_data_i;
                end else if (core_gnt_o && core_we_i && (core_addr_i == IDX_W'(k))) begin
                    mem_q[k] <= core_wdata_i;
                end
            end
        end
    end

    // ---------------- Burst bookkeeping ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            done_o <= 1'b0;
        end else begin
            if (start_any) begin
                base_q <= xfer_base_i;
                len_q  <= xfer_len_i;
                cnt_q  <= '0;
            end else if (((state_q == LOAD) && ld_hs) || ((state_q == STORE) && st_hs)) begin
                cnt_q <= cnt_q + IDX_W'(1);
            end
            done_o <= start_zero
                   || ((state_q == LOAD)  && ld_hs && cnt_last)
                   || ((state_q == STORE) && st_hs && cnt_last);
        end
    end

    // ---------------- Unload stream output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid_o <= 1'b0;
            st_data_o  <= '0;
        end else if (start_st) begin
            st_valid_o <= 1'b1;
            st_data_o  <= st_fetch_data;
        end else if ((state_q == STORE) && st_hs) begin
            if (cnt_last) begin
                st_valid_o <= 1'b0;
            end else begin
                st_data_o <= st_fetch_data;
            end
        end
    end

    // ---------------- Core read return ----------------
    // Captured at the grant edge, so a read returns the pre-write value of that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rvalid_o <= 1'b0;
            core_rdata_o  <= '0;
        end else begin
            core_rvalid_o <= core_gnt_o && !core_we_i;
            if (core_gnt_o && !core_we_i) begin
                core_rdata_o <= mem_q[core_addr_i];
            end
        end
    end

endmodule

// File: tb/tb_pq_register_file.sv
module tb_pq_register_file;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 32;

    logic                      clk;
    logic                      rst_n;
    logic [NR-1:0][DW-1:0]     acc_wdata;
    logic [NR-1:0]             acc_we;
    logic [NR-1:0][DW-1:0]     rdata_pq;
    logic                      core_req;
    logic                      core_we;
    logic [AW-2:0]             core_addr;
    logic [DW-1:0]             core_wdata;
    logic                      core_gnt;
    logic                      core_rvalid;
    logic [DW-1:0]             core_rdata;
    logic                      ld_start;
    logic                      st_start;
    logic [AW-2:0]             xfer_base;
    logic [AW-1:0]             xfer_len;
    logic                      ld_valid;
    logic [DW-1:0]             ld_data;
    logic                      ld_ready;
    logic                      st_valid;
    logic [DW-1:0]             st_data;
    logic                      st_ready;
    logic                      busy;
    logic                      done;

    // Expected storage contents, updated by hand as each scenario writes.
    logic [NR-1:0][DW-1:0]     exp_mem;

    int assertions = 0;
    int failures   = 0;

    pq_register_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .acc_wdata_i   (acc_wdata),
        .acc_we_i      (acc_we),
        .rdata_pq_o    (rdata_pq),
        .core_req_i    (core_req),
        .core_we_i     (core_we),
        .core_addr_i   (core_addr),
        .core_wdata_i  (core_wdata),
        .core_gnt_o    (core_gnt),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .ld_start_i    (ld_start),
        .st_start_i    (st_start),
        .xfer_base_i   (xfer_base),
        .xfer_len_i    (xfer_len),
        .ld_valid_i    (ld_valid),
        .ld_data_i     (ld_data),
        .ld_ready_o    (ld_ready),
        .st_valid_o    (st_valid),
        .st_data_o     (st_data),
        .st_ready_i    (st_ready),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven there, outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; acc_wdata = '0; acc_we = '0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        ld_start = 1'b0; st_start = 1'b0; xfer_base = '0; xfer_len = '0;
        ld_valid = 1'b0; ld_data = '0; st_ready = 1'b0;
        exp_mem = '0;
        @(negedge clk);
        assertions++; if (rdata_pq !== '0) begin failures++; $display("FAIL reset_mem got=%h exp=0", rdata_pq); end
        assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        assertions++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        assertions++; if (st_valid !== 1'b0 || st_data !== '0) begin failures++; $display("FAIL reset_st got=%b/%h exp=0/0", st_valid, st_data); end
        assertions++; if (core_rvalid !== 1'b0 || core_rdata !== '0) begin failures++; $display("FAIL reset_core got=%b/%h exp=0/0", core_rvalid, core_rdata); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_acc_write();
        acc_we = 32'h0000_0005;
        acc_wdata[0] = 32'h1111_2222;
        acc_wdata[2] = 32'h3333_4444;
        @(negedge clk);
        assertions++; if (rdata_pq[0] !== 32'h0) begin failures++; $display("FAIL acc_no_bypass got=%h exp=0", rdata_pq[0]); end
        tick();
        acc_we = '0;
        exp_mem[0] = 32'h1111_2222;
        exp_mem[2] = 32'h3333_4444;
        @(negedge clk);
        assertions++; if (rdata_pq[0] !== 32'h1111_2222) begin failures++; $display("FAIL acc_e0 got=%h exp=11112222", rdata_pq[0]); end
        assertions++; if (rdata_pq[2] !== 32'h3333_4444) begin failures++; $display("FAIL acc_e2 got=%h exp=33334444", rdata_pq[2]); end
        assertions++; if (rdata_pq !== exp_mem) begin failures++; $display("FAIL acc_all got=%h exp=%h", rdata_pq, exp_mem); end
        tick();
    endtask

    task automatic test_core_rw();
        core_req = 1'b1; core_we = 1'b1; core_addr = 5'd7; core_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        assertions++; if (core_gnt !== 1'b1) begin failures++; $display("FAIL core_wr_gnt got=%b exp=1", core_gnt); end
        tick();
        core_we = 1'b0;
        exp_mem[7] = 32'hDEAD_BEEF;
        @(negedge clk);
        assertions++; if (core_gnt !== 1'b1) begin failures++; $display("FAIL core_rd_gnt got=%b exp=1", core_gnt); end
        assertions++; if (core_rvalid !== 1'b0) begin failures++; $display("FAIL core_rvalid_after_wr got=%b exp=0", core_rvalid); end
        assertions++; if (rdata_pq[7] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL core_wr_e7 got=%h exp=deadbeef", rdata_pq[7]); end
        tick();
        core_req = 1'b0;
        @(negedge clk);
        assertions++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL core_rd_data got=%b/%h exp=1/deadbeef", core_rvalid, core_rdata); end
        tick();
        @(negedge clk);
        assertions++; if (core_rvalid !== 1'b0 || core_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL core_rd_hold got=%b/%h exp=0/deadbeef", core_rvalid, core_rdata); end
        tick();
    endtask

    task automatic test_core_conflict();
        core_req = 1'b1; core_we = 1'b1; core_addr = 5'd3; core_wdata = 32'hAAAA_0003;
        acc_we = 32'h0000_0008; acc_wdata[3] = 32'h1234_5678;
        @(negedge clk);
        assertions++; if (core_gnt !== 1'b0) begin failures++; $display("FAIL conflict_gnt_blocked got=%b exp=0", core_gnt); end
        tick();
        acc_we = '0;
        exp_mem[3] = 32'h1234_5678;
        @(negedge clk);
        assertions++; if (core_gnt !== 1'b1) begin failures++; $display("FAIL conflict_gnt_late got=%b exp=1", core_gnt); end
        assertions++; if (rdata_pq[3] !== 32'h1234_5678) begin failures++; $display("FAIL conflict_acc_wins got=%h exp=12345678", rdata_pq[3]); end
        tick();
        core_req = 1'b0;
        exp_mem[3] = 32'hAAAA_0003;
        @(negedge clk);
        assertions++; if (rdata_pq[3] !== 32'hAAAA_0003) begin failures++; $display("FAIL conflict_core_wr got=%h exp=aaaa0003", rdata_pq[3]); end
        tick();
    endtask

    task automatic test_load_wrap();
        ld_start = 1'b1; xfer_base = 5'd30; xfer_len = 6'd4;
        @(negedge clk);
        assertions++; if (busy !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL load_idle got=%b/%b exp=0/0", busy, ld_ready); end
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            @(negedge clk);
            assertions++; if (busy !== 1'b1 || ld_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL load_gap%0d busy/rdy/done got=%b/%b/%b exp=1/1/0", i, busy, ld_ready, done); end
            tick();
            if (i == 2) begin
                // Accelerator write elsewhere stalls the stream; the offered word must not be consumed.
                ld_valid = 1'b1; ld_data = 32'd3;
                acc_we = 32'h0010_0000; acc_wdata[20] = 32'h5555_5555;
                @(negedge clk);
                assertions++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL load_acc_stall got=%b exp=0", ld_ready); end
                tick();
                acc_we = '0;
                exp_mem[20] = 32'h5555_5555;
            end
            ld_valid = 1'b1; ld_data = DW'(i + 1);
            tick();
        end
        ld_valid = 1'b0;
        exp_mem[30] = 32'd1; exp_mem[31] = 32'd2; exp_mem[0] = 32'd3; exp_mem[1] = 32'd4;
        @(negedge clk);
        assertions++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL load_done done/busy got=%b/%b exp=1/0", done, busy); end
        assertions++; if (rdata_pq !== exp_mem) begin failures++; $display("FAIL load_mem got=%h exp=%h", rdata_pq, exp_mem); end
        tick();
        @(negedge clk);
        assertions++; if (done !== 1'b0) begin failures++; $display("FAIL load_done_pulse got=%b exp=0", done); end
        tick();
    endtask

    task automatic test_store_stall();
        acc_we = 32'h0000_0060; acc_wdata[5] = 32'h0505_0505; acc_wdata[6] = 32'h0606_0606;
        tick();
        acc_we = '0;
        exp_mem[5] = 32'h0505_0505; exp_mem[6] = 32'h0606_0606;
        st_start = 1'b1; xfer_base = 5'd5; xfer_len = 6'd3; st_ready = 1'b0;
        tick();
        st_start = 1'b0;
        @(negedge clk);
        assertions++; if (st_valid !== 1'b1 || st_data !== exp_mem[5] || busy !== 1'b1) begin failures++; $display("FAIL store_first got=%b/%h/%b exp=1/%h/1", st_valid, st_data, busy, exp_mem[5]); end
        tick();
        // A load start while busy must be ignored.
        ld_start = 1'b1; xfer_base = 5'd0; xfer_len = 6'd1;
        @(negedge clk);
        assertions++; if (st_valid !== 1'b1 || st_data !== exp_mem[5]) begin failures++; $display("FAIL store_stall_hold got=%b/%h exp=1/%h", st_valid, st_data, exp_mem[5]); end
        tick();
        ld_start = 1'b0; st_ready = 1'b1;
        @(negedge clk);
        assertions++; if (ld_ready !== 1'b0 || st_data !== exp_mem[5]) begin failures++; $display("FAIL store_ignore_start rdy/data got=%b/%h exp=0/%h", ld_ready, st_data, exp_mem[5]); end
        tick();
        @(negedge clk);
        assertions++; if (st_valid !== 1'b1 || st_data !== exp_mem[6]) begin failures++; $display("FAIL store_w1 got=%b/%h exp=1/%h", st_valid, st_data, exp_mem[6]); end
        tick();
        @(negedge clk);
        assertions++; if (st_valid !== 1'b1 || st_data !== exp_mem[7] || done !== 1'b0) begin failures++; $display("FAIL store_w2 got=%b/%h/%b exp=1/%h/0", st_valid, st_data, done, exp_mem[7]); end
        tick();
        st_ready = 1'b0;
        @(negedge clk);
        assertions++; if (st_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL store_done v/done/busy got=%b/%b/%b exp=0/1/0", st_valid, done, busy); end
        tick();
        @(negedge clk);
        assertions++; if (done !== 1'b0) begin failures++; $display("FAIL store_done_pulse got=%b exp=0", done); end
        tick();
    endtask

    task automatic test_reset_mid_load_zero_len();
        ld_start = 1'b1; xfer_base = 5'd10; xfer_len = 6'd8;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hA1;
        tick();
        ld_data = 32'hA2;
        tick();
        ld_valid = 1'b0;
        #2;
        assertions++; if (rdata_pq[11] !== 32'hA2 || busy !== 1'b1) begin failures++; $display("FAIL midload_progress e11/busy got=%h/%b exp=a2/1", rdata_pq[11], busy); end
        rst_n = 1'b0;
        exp_mem = '0;
        #1;
        assertions++; if (rdata_pq !== '0) begin failures++; $display("FAIL async_rst_mem got=%h exp=0", rdata_pq); end
        assertions++; if (busy !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL async_rst_fsm busy/rdy got=%b/%b exp=0/0", busy, ld_ready); end
        assertions++; if (core_rdata !== '0) begin failures++; $display("FAIL async_rst_core_rdata got=%h exp=0", core_rdata); end
        tick();
        rst_n = 1'b1;
        ld_start = 1'b1; st_start = 1'b1; xfer_base = 5'd0; xfer_len = 6'd0;
        @(negedge clk);
        assertions++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zlen_start done/busy got=%b/%b exp=0/0", done, busy); end
        tick();
        ld_start = 1'b0; st_start = 1'b0;
        @(negedge clk);
        assertions++; if (done !== 1'b1 || busy !== 1'b0 || st_valid !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL zlen_done done/busy/stv/rdy got=%b/%b/%b/%b exp=1/0/0/0", done, busy, st_valid, ld_ready); end
        assertions++; if (rdata_pq !== exp_mem) begin failures++; $display("FAIL zlen_mem got=%h exp=0", rdata_pq); end
        tick();
        @(negedge clk);
        assertions++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zlen_after done/busy got=%b/%b exp=0/0", done, busy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_acc_write();
        test_core_rw();
        test_core_conflict();
        test_load_wrap();
        test_store_stall();
        test_reset_mid_load_zero_len();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/pq_register_file.md
Name: pq_register_file

Overview:
- Storage end of the PQ register-file interface driven by the NTT/modular-arithmetic accelerator.
- Holds NUM_REGS = 2**(ADDR_WIDTH-1) words of DATA_WIDTH bits.
- Accepts per-word parallel writes from the accelerator and exposes every word in parallel on the read side.
- Also provides a single-word core load/store port and a burst load/unload stream engine, so polynomials can be moved in and out between NTT passes.

Parameters:
ADDR_WIDTH, 6, register address width; NUM_REGS = 2**(ADDR_WIDTH-1) = 32 words
DATA_WIDTH, 32, word width (two packed 16-bit coefficients)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
acc_wdata_i  in  NUM_REGS x DATA_WIDTH  accelerator write data, one word per entry
acc_we_i  in  NUM_REGS  accelerator per-entry write enable
rdata_pq_o  out  NUM_REGS x DATA_WIDTH  current contents of every entry
core_req_i  in  1  core access request
core_we_i  in  1  1 = write, 0 = read
core_addr_i  in  ADDR_WIDTH-1  core word index
core_wdata_i  in  DATA_WIDTH  core write data
core_gnt_o  out  1  core request accepted this cycle
core_rvalid_o  out  1  core read data valid
core_rdata_o  out  DATA_WIDTH  core read data
ld_start_i  in  1  start burst load
st_start_i  in  1  start burst unload
xfer_base_i  in  ADDR_WIDTH-1  first entry of the burst
xfer_len_i  in  ADDR_WIDTH  burst length in words, 0..NUM_REGS
ld_valid_i  in  1  load stream data valid
ld_data_i  in  DATA_WIDTH  load stream data
ld_ready_o  out  1  load stream ready
st_valid_o  out  1  unload stream data valid
st_data_o  out  DATA_WIDTH  unload stream data
st_ready_i  in  1  unload stream ready
busy_o  out  1  engine in LOAD or STORE
done_o  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (asynchronous, at any time, including mid-burst):
  - all entries and all outputs go to 0
  - FSM goes to IDLE and the counter clears
- Storage and read side:
  - Writes take effect at the clock edge.
  - rdata_pq_o is driven combinationally from the storage flops; there is no bypass, so a written value is visible the cycle after the write.
- Accelerator writes:
  - Any entry with acc_we_i[k]=1 is written with acc_wdata_i[k]. acc_we_i is never stalled.
  - Same-cycle write priority on one entry: accelerator > load stream > core.
  - A lower-priority write that loses is dropped: load data is not consumed (see ld_ready_o), and the core is not granted.
- Core port:
  - core_gnt_o = core_req_i & (FSM==IDLE) & ~|acc_we_i.
  - Granted write: entry written at that edge.
  - Granted read: core_rvalid_o=1 the next cycle, with core_rdata_o = entry value at the grant edge (pre-write value).
  - core_rdata_o holds its value when core_rvalid_o=0.
- FSM states: IDLE, LOAD, STORE; 5-bit word counter cnt.
- IDLE transitions:
  - ld_start_i goes to LOAD; ld_start_i has priority over a simultaneous st_start_i, which is ignored.
  - st_start_i alone goes to STORE.
  - xfer_base_i and xfer_len_i are latched when the start is taken; cnt clears to 0.
  - If xfer_len_i==0: stay in IDLE, done_o pulses the next cycle, no writes or reads.
  - Starts received while busy are ignored.
- LOAD:
  - ld_ready_o = ~|acc_we_i (combinational).
  - On ld_valid_i & ld_ready_o, write entry (base+cnt) mod NUM_REGS (address wraps) and increment cnt.
  - The handshake with cnt==len-1 returns the FSM to IDLE; done_o pulses the next cycle.
- STORE:
  - st_valid_o and st_data_o are registered.
  - The first word is valid the cycle after the start is taken, with address (base+cnt) mod NUM_REGS.
  - st_data_o stays stable while st_valid_o & ~st_ready_i.
  - On the handshake, the next word is presented the following cycle, so the stream runs back-to-back at one word per cycle.
  - Words read during STORE reflect accelerator writes up to the cycle before they are presented.
  - The last handshake sets st_valid_o to 0, returns the FSM to IDLE, and pulses done_o the next cycle.
- busy_o = (FSM != IDLE).

Test Plan:
- Reset, then acc_we_i=32'h0000_0005 with entry 0 = 32'h1111_2222 and entry 2 = 32'h3333_4444 -> next cycle rdata_pq_o[0]=32'h1111_2222, rdata_pq_o[2]=32'h3333_4444, all other entries 0.
- Core write 0xDEADBEEF to entry 7, then core read of entry 7 -> core_gnt_o=1 both cycles; core_rvalid_o=1 one cycle after the read grant; core_rdata_o=0xDEADBEEF.
- Core request in the same cycle as acc_we_i[3]=1 -> core_gnt_o=0; grant is issued the first cycle acc_we_i==0.
- ld_start_i with base=30, len=4, data 1,2,3,4, ld_valid_i toggling -> entries 30,31,0,1 = 1,2,3,4; done_o pulses once; busy_o falls together with the last handshake's return to IDLE.
- st_start_i with base=5, len=3, st_ready_i low for 2 cycles then high -> st_data_o holds entry 5 while stalled, then emits entries 5,6,7, then done_o.
- Reset asserted mid-LOAD after 2 of 8 words, then ld_start_i and st_start_i asserted together with len=0 -> all entries 0, FSM IDLE; load start wins, done_o pulses next cycle, no writes.
